// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the responder FSM state type
package ahb_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic HTRANS_IDLE = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;
endpackage

// File: rtl/ahb_wstrb_gen.sv
// ahb_wstrb_gen: little-endian byte strobe and misalignment flag from hsize and addr[1:0]
module ahb_wstrb_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       misalign
);
  always_comb begin
    strb = size == HSIZE_BYTE ? 4'b0001 << addr :
           size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
           size == HSIZE_WORD ? 4'b1111 : 4'b0000;
    misalign = (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr != 2'b00);
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite responder over a word array with wait states and two-cycle ERROR
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_hselx,
  input  logic                  i_hready,
  input  logic                  i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int IW = $clog2(MEM_DEPTH);
  state_t state, state_n, acc_state;
  logic [3:0] cnt;
  logic [IW-1:0] idx_q;
  logic [3:0] strb_q, strb;
  logic write_q, misalign, accept, err;
  logic [ADDR_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  ahb_wstrb_gen u_wstrb (
    .size(i_hsize),
    .addr(i_haddr[1:0]),
    .strb(strb),
    .misalign(misalign)
  );
  assign off = i_haddr - BASE_ADDR;
  assign accept = i_hselx && i_htrans == HTRANS_ACTIVE && i_hready;
  assign err = i_haddr < BASE_ADDR || (off >> 2) >= ADDR_WIDTH'(MEM_DEPTH) ||
               i_hsize > HSIZE_WORD || misalign;
  always_comb begin
    acc_state = !accept ? IDLE : err ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
    state_n = state == WAIT ? (cnt == 4'd0 ? DATA : WAIT) : state == ERR1 ? ERR2 : acc_state;
    o_hreadyout = !(state == WAIT || state == ERR1);
    o_hresp = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    o_hrdata = (state == DATA && !write_q) ? mem[idx_q] : '0;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      strb_q <= '0;
      write_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx_q <= off[IW+1:2];
        strb_q <= strb;
        write_q <= i_hwrite;
        cnt <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == DATA && write_q)
        for (int b = 0; b < 4; b++)
          if (strb_q[b]) mem[idx_q][8*b+:8] <= i_hwdata[8*b+:8];
    end
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed AHB-Lite transfers against responders with 0, 1 and 3 wait states
module tb_ahb_slave_mem;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] sel = '0;
  logic htrans = 1'b0, hwrite = 1'b0;
  logic [2:0] hsize = '0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [2:0] rdy, resp;
  logic [31:0] rd [3];
  int tgt = 0;
  int checks = 0, failures = 0;
  logic bus_ready, bus_resp;
  logic [31:0] bus_rdata;
  always #5 clk = ~clk;
  assign bus_ready = rdy[tgt];
  assign bus_resp = resp[tgt];
  assign bus_rdata = rd[tgt];
  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rstn(rst_n), .i_hselx(sel[0]), .i_hready(bus_ready), .i_htrans(htrans),
    .i_hsize(hsize), .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata),
    .o_hreadyout(rdy[0]), .o_hresp(resp[0]), .o_hrdata(rd[0]));
  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .i_clk(clk), .i_rstn(rst_n), .i_hselx(sel[1]), .i_hready(bus_ready), .i_htrans(htrans),
    .i_hsize(hsize), .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata),
    .o_hreadyout(rdy[1]), .o_hresp(resp[1]), .o_hrdata(rd[1]));
  ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rstn(rst_n), .i_hselx(sel[2]), .i_hready(bus_ready), .i_htrans(htrans),
    .i_hsize(hsize), .i_hwrite(hwrite), .i_haddr(haddr), .i_hwdata(hwdata),
    .o_hreadyout(rdy[2]), .o_hresp(resp[2]), .o_hrdata(rd[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic addr_phase(input int t, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    tgt = t;
    sel = 3'(1 << t);
    htrans = 1'b1;
    hwrite = wr;
    hsize = sz;
    haddr = a;
  endtask

  task automatic bus_idle();
    sel = '0;
    htrans = 1'b0;
  endtask

  // one non-pipelined transfer; counts low-ready cycles before the final data-phase cycle
  task automatic xfer(input string tag, input int t, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input int exp_w, input logic exp_e);
    int w;
    logic re;
    addr_phase(t, wr, sz, a);
    @(posedge clk); #1;
    bus_idle();
    hwdata = wd;
    w = 0;
    re = 1'b0;
    while (!bus_ready && w < 20) begin
      re |= bus_resp;
      w++;
      @(posedge clk); #1;
    end
    check({tag, "_waits"}, 32'(w), 32'(exp_w));
    check({tag, "_resp"}, {31'b0, bus_resp}, {31'b0, exp_e});
    if (exp_w > 0) check({tag, "_resp_low"}, {31'b0, re}, {31'b0, exp_e});
    check({tag, "_rdata"}, bus_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tgt = k;
      #0;
      check($sformatf("rst_ready%0d", k), {31'b0, bus_ready}, 32'd1);
      check($sformatf("rst_resp%0d", k), {31'b0, bus_resp}, 32'd0);
      check($sformatf("rst_rdata%0d", k), bus_rdata, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer("ws1_rd0", 1, 1'b0, 3'd2, 32'h00, 32'h0, 32'h0, 1, 1'b0);
    addr_phase(0, 1'b1, 3'd2, 32'h10);
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF;
    check("pipe_wr_ready", {31'b0, bus_ready}, 32'd1);
    addr_phase(0, 1'b0, 3'd2, 32'h10);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h0;
    check("pipe_rd_ready", {31'b0, bus_ready}, 32'd1);
    check("pipe_rd_data", bus_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("pipe_idle_rdata", bus_rdata, 32'h0);
    xfer("ws0_rd10", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    xfer("byte_wr", 1, 1'b1, 3'd0, 32'h11, 32'h1122AA33, 32'h0, 1, 1'b0);
    xfer("half_wr", 1, 1'b1, 3'd1, 32'h12, 32'h55667788, 32'h0, 1, 1'b0);
    xfer("lanes_rd", 1, 1'b0, 3'd2, 32'h10, 32'h0, 32'h5566AA00, 1, 1'b0);
    xfer("byte_rd", 1, 1'b0, 3'd0, 32'h13, 32'h0, 32'h5566AA00, 1, 1'b0);
    xfer("oor_rd", 1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1, 1'b1);
    xfer("after_err", 1, 1'b0, 3'd2, 32'h10, 32'h0, 32'h5566AA00, 1, 1'b0);
    xfer("oor_wr", 1, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 1'b1);
    xfer("no_alias", 1, 1'b0, 3'd2, 32'h00, 32'h0, 32'h0, 1, 1'b0);
    xfer("misal_wr", 1, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 32'h0, 1, 1'b1);
    xfer("size3_wr", 1, 1'b1, 3'd3, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1'b1);
    xfer("misal_chk", 1, 1'b0, 3'd2, 32'h00, 32'h0, 32'h0, 1, 1'b0);
    xfer("size3_chk", 1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 1, 1'b0);
    xfer("ws0_err", 0, 1'b0, 3'd1, 32'h05, 32'h0, 32'h0, 1, 1'b1);
    xfer("ws3_wr", 2, 1'b1, 3'd2, 32'h0C, 32'hCAFEF00D, 32'h0, 3, 1'b0);
    xfer("ws3_rd", 2, 1'b0, 3'd2, 32'h0C, 32'h0, 32'hCAFEF00D, 3, 1'b0);
    addr_phase(2, 1'b1, 3'd2, 32'h08);
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'h12345678;
    check("rstmid_wait1", {31'b0, bus_ready}, 32'd0);
    @(posedge clk); #1;
    check("rstmid_wait2", {31'b0, bus_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", {31'b0, bus_ready}, 32'd1);
    check("rstmid_resp", {31'b0, bus_resp}, 32'd0);
    check("rstmid_rdata", bus_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hwdata = 32'h0;
    @(posedge clk); #1;
    xfer("rst_rd08", 2, 1'b0, 3'd2, 32'h08, 32'h0, 32'h0, 3, 1'b0);
    xfer("rst_rd0c", 2, 1'b0, 3'd2, 32'h0C, 32'h0, 32'h0, 3, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
